// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between the control unit (master) and alu_sequencer (slave).
interface alu_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_mode;
    logic [7:0] req_op1;
    logic [7:0] req_op2;
    logic [2:0] req_dest;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rsp_dest;
    logic [3:0] rsp_flags;

    modport master (
        output req_valid, req_mode, req_op1, req_op2, req_dest, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_dest, rsp_flags
    );

    modport slave (
        input  req_valid, req_mode, req_op1, req_op2, req_dest, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_dest, rsp_flags
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issues one op at a time to the combinational ALU, owns the {Z,C,S,O} status register.
// Optional STATUS_SHADOW_EN builds an interrupt shadow copy of status.
module alu_sequencer (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_sequencer_if.slave        bus,
    output logic                  alu_e_o,
    output logic [3:0]            alu_mode_o,
    output logic [7:0]            alu_op1_o,
    output logic [7:0]            alu_op2_o,
    output logic [3:0]            alu_cflags_o,
    input  logic [7:0]            alu_out_i,
    input  logic [3:0]            alu_flags_i,
    output logic [3:0]            status_o,
    input  logic                  status_wr_en_i,
    input  logic [3:0]            status_wr_data_i,
    input  logic [2:0]            cond_sel_i,
    output logic                  cond_true_o,
    input  logic                  irq_enter_i,
    input  logic                  irq_return_i
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] mode_q;
    logic [7:0] op1_q, op2_q;
    logic [2:0] dest_q;
    logic [7:0] data_q;
    logic [3:0] rflags_q;
    logic [3:0] status_q, status_d;
    logic       arith;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = DRIVE;
            DRIVE:   state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (mode_q)
            4'b0000, 4'b0001, 4'b0111, 4'b1000, 4'b1001, 4'b1111: arith = 1'b1;
            default:                                              arith = 1'b0;
        endcase
    end

`ifdef STATUS_SHADOW_EN
    logic [3:0] shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shadow_q <= 4'd0;
        else if (irq_enter_i && !irq_return_i)
            shadow_q <= status_q;
    end
`else
    logic unused_irq;
    assign unused_irq = irq_enter_i ^ irq_return_i;
`endif

    // Lowest priority first so later assignments win: capture, direct load, restore.
    always_comb begin
        status_d = status_q;
        if (state_q == DRIVE)
            status_d = arith ? alu_flags_i
                             : {alu_flags_i[3], status_q[2], alu_flags_i[1], status_q[0]};
        if (status_wr_en_i)
            status_d = status_wr_data_i;
`ifdef STATUS_SHADOW_EN
        if (irq_return_i)
            status_d = shadow_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= 4'd0;
            op1_q    <= 8'd0;
            op2_q    <= 8'd0;
            dest_q   <= 3'd0;
            data_q   <= 8'd0;
            rflags_q <= 4'd0;
            status_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (state_q == IDLE && bus.req_valid) begin
                mode_q <= bus.req_mode;
                op1_q  <= bus.req_op1;
                op2_q  <= bus.req_op2;
                dest_q <= bus.req_dest;
            end
            if (state_q == DRIVE) begin
                data_q   <= alu_out_i;
                rflags_q <= alu_flags_i;
            end
        end
    end

    always_comb begin
        case (cond_sel_i)
            3'b000:  cond_true_o = 1'b1;
            3'b001:  cond_true_o = status_q[3];
            3'b010:  cond_true_o = !status_q[3];
            3'b011:  cond_true_o = status_q[2];
            3'b100:  cond_true_o = !status_q[2];
            3'b101:  cond_true_o = status_q[1];
            3'b110:  cond_true_o = status_q[0];
            default: cond_true_o = status_q[1] ^ status_q[0];
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_dest  = dest_q;
    assign bus.rsp_flags = rflags_q;
    assign alu_e_o       = (state_q == DRIVE);
    assign alu_mode_o    = mode_q;
    assign alu_op1_o     = op1_q;
    assign alu_op2_o     = op2_q;
    assign alu_cflags_o  = status_q;
    assign status_o      = status_q;
endmodule
